// File: rtl/seq_multiplier_radix_pkg.sv
// Shared definitions for the radix-2^k sequential multiplier:
// FSM state encoding, counter-width helper and legal-radix check.
package seq_multiplier_radix_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Number of bits needed to count 0 .. value-1.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 32'sd1;
    r = 32'sd0;
    while (v > 32'sd0) begin
      r = r + 32'sd1;
      v = v >>> 1;
    end
    return r;
  endfunction

  // Radix sizes the digit partial-product logic is built for.
  function automatic bit radix_is_legal(input int radix_bits);
    return (radix_bits == 32'sd1) || (radix_bits == 32'sd2) || (radix_bits == 32'sd4);
  endfunction

endpackage

// File: rtl/seq_multiplier_radix_digit_pp.sv
// Partial product of one multiplier digit and the multiplicand.
// In signed mode the multiplicand is sign-extended, and the top digit's MSB
// carries negative weight (subtracted), which makes the whole sum a
// two's-complement product. Lower digits are always unsigned.
module seq_multiplier_radix_digit_pp #(
  parameter int WIDTH      = 512,
  parameter int RADIX_BITS = 2
) (
  input  logic [RADIX_BITS-1:0]       i_digit,
  input  logic [WIDTH-1:0]            i_multiplicand,
  input  logic                        i_is_top,
  input  logic                        i_signed_mode,
  output logic signed [WIDTH+RADIX_BITS:0] o_pp
);

  localparam int PPW = WIDTH + RADIX_BITS + 1;

  logic                  w_mcand_sign;
  logic                  w_top_signed;
  logic signed [PPW-1:0] w_mcand_ext;
  logic signed [PPW-1:0] w_term;
  logic signed [PPW-1:0] w_pp;

  assign w_mcand_sign = i_signed_mode & i_multiplicand[WIDTH-1];
  assign w_top_signed = i_signed_mode & i_is_top;
  assign w_mcand_ext  = {{(RADIX_BITS + 1){w_mcand_sign}}, i_multiplicand};

  // Shift-and-add over the digit bits; the signed top digit subtracts its MSB term.
  always_comb begin
    w_pp   = {PPW{1'b0}};
    w_term = {PPW{1'b0}};
    for (int j = 0; j < RADIX_BITS; j++) begin
      if (i_digit[j]) begin
        w_term = w_mcand_ext <<< j;
      end else begin
        w_term = {PPW{1'b0}};
      end
      if ((j == (RADIX_BITS - 1)) && w_top_signed) begin
        w_pp = w_pp - w_term;
      end else begin
        w_pp = w_pp + w_term;
      end
    end
  end

  assign o_pp = w_pp;

endmodule

// File: rtl/seq_multiplier_radix.sv
// Constant-time sequential multiplier retiring RADIX_BITS multiplier bits per
// cycle. Every RUN cycle performs the add (zero digits included), so latency
// is exactly WIDTH/RADIX_BITS RUN cycles regardless of operand values.
module seq_multiplier_radix
  import seq_multiplier_radix_pkg::*;
#(
  parameter int WIDTH      = 512,
  parameter int RADIX_BITS = 2,
  parameter int SIGNED_EN  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int N   = WIDTH / RADIX_BITS;
  localparam int CW  = (clog2(N) > 0) ? clog2(N) : 1;
  localparam int AW  = 2 * WIDTH + RADIX_BITS + 1;
  localparam int PPW = WIDTH + RADIX_BITS + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  if (!radix_is_legal(RADIX_BITS) || ((WIDTH % RADIX_BITS) != 0)) begin : g_bad_params
    $error("seq_multiplier_radix: RADIX_BITS must be 1, 2 or 4 and divide WIDTH");
  end

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [WIDTH-1:0]      r_mplier;
  logic [WIDTH-1:0]      r_mcand;
  logic                  r_signed;
  logic signed [AW-1:0]  r_acc;
  logic [2*WIDTH-1:0]    r_product;
  logic                  r_out_valid;
  logic                  r_in_ready;
  logic                  w_out_valid_nxt;
  logic                  w_in_ready_nxt;

  logic                  w_is_top;
  logic signed [PPW-1:0] w_pp;
  logic signed [AW-1:0]  w_pp_ext;
  logic signed [AW-1:0]  w_acc_sum;
  logic signed [AW-1:0]  w_acc_shift;

  assign w_is_top = (r_cnt == CNT_LAST);

  seq_multiplier_radix_digit_pp #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS)
  ) u_digit_pp (
    .i_digit        (r_mplier[RADIX_BITS-1:0]),
    .i_multiplicand (r_mcand),
    .i_is_top       (w_is_top),
    .i_signed_mode  (r_signed),
    .o_pp           (w_pp)
  );

  // Partial product enters at bit WIDTH; the arithmetic shift keeps the sign
  // of the running sum while retiring one digit per cycle.
  assign w_pp_ext    = {{WIDTH{w_pp[PPW-1]}}, w_pp};
  assign w_acc_sum   = r_acc + (w_pp_ext <<< WIDTH);
  assign w_acc_shift = w_acc_sum >>> RADIX_BITS;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_is_top) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM output decode, taken from the next state so the handshake flags can be registered.
  always_comb begin
    w_in_ready_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;
    case (w_state_nxt)
      S_IDLE: begin
        w_in_ready_nxt  = 1'b1;
        w_out_valid_nxt = 1'b0;
      end
      S_RUN: begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
      end
      S_DONE: begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b1;
      end
      default: begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // Registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Datapath: operand capture, one digit per RUN cycle, product capture on the last digit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= {CW{1'b0}};
      r_mplier  <= {WIDTH{1'b0}};
      r_mcand   <= {WIDTH{1'b0}};
      r_signed  <= 1'b0;
      r_acc     <= {AW{1'b0}};
      r_product <= {(2*WIDTH){1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mplier <= multiplier;
            r_mcand  <= multiplicand;
            r_signed <= signed_mode & (SIGNED_EN != 0);
            r_acc    <= {AW{1'b0}};
            r_cnt    <= {CW{1'b0}};
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_shift;
          r_mplier <= r_mplier >> RADIX_BITS;
          r_cnt    <= r_cnt + CW'(1'b1);
          if (w_is_top) begin
            r_product <= w_acc_shift[2*WIDTH-1:0];
          end
        end
        S_DONE: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = r_product;

endmodule

// File: tb/tb_seq_multiplier_radix.sv
// Self-checking bench for seq_multiplier_radix: directed cases on an 8-bit
// radix-4 instance, random traffic on 8-bit (radix 4) and 64-bit (radix 16)
// instances, compared against a plain-arithmetic product model.
module tb_seq_multiplier_radix;

  localparam int AWD = 8;
  localparam int AR  = 2;
  localparam int AN  = AWD / AR;
  localparam int BWD = 64;
  localparam int BR  = 4;
  localparam int BN  = BWD / BR;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_signed, a_out_valid, a_out_ready;
  logic [7:0]  a_mplier, a_mcand;
  logic [15:0] a_product;

  logic         b_in_valid, b_in_ready, b_signed, b_out_valid, b_out_ready;
  logic [63:0]  b_mplier, b_mcand;
  logic [127:0] b_product;

  int n_checks = 0;
  int n_fail   = 0;

  seq_multiplier_radix #(.WIDTH(AWD), .RADIX_BITS(AR), .SIGNED_EN(1)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .signed_mode(a_signed), .multiplier(a_mplier), .multiplicand(a_mcand),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .product(a_product)
  );

  seq_multiplier_radix #(.WIDTH(BWD), .RADIX_BITS(BR), .SIGNED_EN(1)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .signed_mode(b_signed), .multiplier(b_mplier), .multiplicand(b_mcand),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .product(b_product)
  );

  // Reference: extend both operands to full product width (sign or zero) and multiply mod 2^(2W).
  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [15:0] xe, ye;
    xe = {{8{s & x[7]}}, x};
    ye = {{8{s & y[7]}}, y};
    return xe * ye;
  endfunction

  function automatic logic [127:0] model64(input logic [63:0] x, input logic [63:0] y, input logic s);
    logic [127:0] xe, ye;
    xe = {{64{s & x[63]}}, x};
    ye = {{64{s & y[63]}}, y};
    return xe * ye;
  endfunction

  function automatic logic [63:0] pick64();
    logic [63:0] v;
    int sel;
    sel = int'($urandom_range(0, 6));
    case (sel)
      0:       v = 64'd0;
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       v = 64'h8000_0000_0000_0000;
      3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Issue one operation on instance A; returns the product seen when out_valid first rises
  // and the number of clock edges from the accepting edge to that point.
  task automatic run_op_a(input logic [7:0] mp, input logic [7:0] mc, input logic s,
                          output logic [15:0] prod, output int lat);
    int k;
    k = 0;
    @(negedge clk);
    while (a_in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    a_mplier = mp; a_mcand = mc; a_signed = s; a_in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    a_mplier = 8'($urandom); a_mcand = 8'($urandom); a_signed = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (a_out_valid !== 1'b1 && lat < 50);
    prod = a_product;
  endtask

  task automatic consume_a();
    @(negedge clk);
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;
  endtask

  task automatic run_op_b(input logic [63:0] mp, input logic [63:0] mc, input logic s,
                          output logic [127:0] prod, output int lat);
    int k;
    k = 0;
    @(negedge clk);
    while (b_in_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    b_mplier = mp; b_mcand = mc; b_signed = s; b_in_valid = 1'b1;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    b_mplier = {$urandom, $urandom}; b_mcand = {$urandom, $urandom};
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (b_out_valid !== 1'b1 && lat < 100);
    prod = b_product;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    n_checks++;
    if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    n_checks++;
    if (a_product !== 16'h0000) begin n_fail++; $display("FAIL reset_product: got %h want 0000", a_product); end
    n_checks++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_b_flags: in_ready=%b out_valid=%b want 1/0", b_in_ready, b_out_valid);
    end
    rst = 1'b1;
  endtask

  // Fixed cases with hand-computed products; out_valid is due after edge N, i.e. in cycle N+1.
  task automatic test_directed();
    logic [7:0]  mp [6];
    logic [7:0]  mc [6];
    logic        sg [6];
    logic [15:0] ex [6];
    logic [15:0] p;
    int          lat;
    mp = '{8'hFF, 8'h80, 8'hFF, 8'hFF, 8'h7F, 8'h00};
    mc = '{8'hFF, 8'h80, 8'h03, 8'h03, 8'h80, 8'h55};
    sg = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1};
    ex = '{16'hFE01, 16'h4000, 16'hFFFD, 16'h02FD, 16'hC080, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      run_op_a(mp[i], mc[i], sg[i], p, lat);
      n_checks++;
      if (p !== ex[i]) begin
        n_fail++; $display("FAIL directed_%0d product: got %h want %h", i, p, ex[i]);
      end
      n_checks++;
      if (lat !== AN) begin
        n_fail++; $display("FAIL directed_%0d latency: got %0d want %0d", i, lat, AN);
      end
      consume_a();
    end
  endtask

  task automatic test_constant_time();
    logic [15:0] p0, p1;
    int          lat0, lat1, k;
    run_op_a(8'h00, 8'hAB, 1'b0, p0, lat0);
    consume_a();
    run_op_a(8'hFF, 8'hAB, 1'b0, p1, lat1);
    consume_a();
    n_checks++;
    if (p0 !== 16'h0000 || p1 !== 16'hAA55) begin
      n_fail++; $display("FAIL ct_products: got %h/%h want 0000/aa55", p0, p1);
    end
    n_checks++;
    if (lat0 !== AN || lat1 !== lat0) begin
      n_fail++; $display("FAIL ct_latency: got %0d/%0d want %0d/%0d", lat0, lat1, AN, AN);
    end
    // in_valid held high through RUN and DONE must be ignored.
    @(negedge clk);
    a_mplier = 8'h12; a_mcand = 8'h34; a_signed = 1'b0; a_in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_mplier = 8'h77; a_mcand = 8'h99; a_signed = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      n_checks++;
      if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL ct_busy_in_ready: got %b want 0 at step %0d", a_in_ready, k); end
    end while (a_out_valid !== 1'b1 && k < 50);
    n_checks++;
    if (a_product !== 16'h03A8) begin n_fail++; $display("FAIL ct_ignored_in_valid: got %h want 03a8", a_product); end
    // Same DONE cycle in_valid and out_ready: only the output handshake happens.
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    a_in_valid  = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ct_done_both: in_ready=%b out_valid=%b want 1/0", a_in_ready, a_out_valid);
    end
    repeat (AN + 2) begin
      @(negedge clk);
      n_checks++;
      if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL ct_no_queued_op: out_valid=%b want 0", a_out_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] p, ex;
    int          lat;
    ex = model8(8'hC3, 8'h5A, 1'b1);
    a_out_ready = 1'b0;
    run_op_a(8'hC3, 8'h5A, 1'b1, p, lat);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (a_out_valid !== 1'b1 || a_product !== ex || a_in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: out_valid=%b product=%h in_ready=%b want 1/%h/0",
                 i, a_out_valid, a_product, a_in_ready, ex);
      end
      @(negedge clk);
    end
    consume_a();
    @(negedge clk);
    n_checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0", a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] p;
    int          lat;
    @(negedge clk);
    a_mplier = 8'hFF; a_mcand = 8'hFF; a_signed = 1'b0; a_in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a_out_valid !== 1'b0 || a_product !== 16'h0000 || a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_state: out_valid=%b product=%h in_ready=%b want 0/0000/1",
               a_out_valid, a_product, a_in_ready);
    end
    repeat (AN + 2) begin
      @(negedge clk);
      n_checks++;
      if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_partial: out_valid=%b want 0", a_out_valid); end
    end
    run_op_a(8'd7, 8'd6, 1'b0, p, lat);
    n_checks++;
    if (p !== 16'd42 || lat !== AN) begin
      n_fail++; $display("FAIL midrst_fresh_op: product=%0d lat=%0d want 42/%0d", p, lat, AN);
    end
    consume_a();
  endtask

  task automatic test_random_a();
    logic [7:0]  mp, mc;
    logic        s;
    logic [15:0] p, ex;
    int          lat;
    for (int i = 0; i < 400; i++) begin
      mp = 8'($urandom); mc = 8'($urandom); s = 1'($urandom);
      ex = model8(mp, mc, s);
      a_out_ready = 1'($urandom);
      run_op_a(mp, mc, s, p, lat);
      n_checks++;
      if (p !== ex || lat !== AN) begin
        n_fail++;
        $display("FAIL rand_a_%0d: %h*%h s=%b product=%h lat=%0d want %h/%0d", i, mp, mc, s, p, lat, ex, AN);
      end
      consume_a();
    end
  endtask

  task automatic test_random_b();
    logic [63:0]  mp, mc;
    logic         s;
    logic [127:0] p, ex;
    int           lat;
    for (int i = 0; i < 1500; i++) begin
      mp = pick64(); mc = pick64(); s = 1'($urandom);
      ex = model64(mp, mc, s);
      b_out_ready = 1'($urandom);
      run_op_b(mp, mc, s, p, lat);
      n_checks++;
      if (p !== ex || lat !== BN) begin
        n_fail++;
        $display("FAIL rand_b_%0d: %h*%h s=%b product=%h lat=%0d want %h/%0d", i, mp, mc, s, p, lat, ex, BN);
      end
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
      @(negedge clk);
      b_out_ready = 1'b1;
      @(posedge clk);
      #1;
      b_out_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0;
    a_in_valid = 1'b0; a_signed = 1'b0; a_out_ready = 1'b0; a_mplier = 8'd0; a_mcand = 8'd0;
    b_in_valid = 1'b0; b_signed = 1'b0; b_out_ready = 1'b0; b_mplier = 64'd0; b_mcand = 64'd0;
    test_reset();
    test_directed();
    test_constant_time();
    test_backpressure();
    test_reset_mid_run();
    test_random_a();
    test_random_b();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
